// File: rtl/ssf_io_host_if.sv
// ssf_io_host_if: bundles the sample stream, processor I/O port and output
// stream signals of ssf_io_host. The slave modport is the host block, the
// master modport is whatever drives it (upstream source, core, sink).
interface ssf_io_host_if #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2
);
  localparam int IPW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int OPW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

  logic [NUBITS-1:0] s_data;
  logic [IPW-1:0]    s_port;
  logic              s_valid;
  logic              s_ready;
  logic [NUBITS-1:0] io_in;
  logic [NUIOIN-1:0] req_in;
  logic [NUBITS-1:0] io_out;
  logic [NUIOOU-1:0] out_en;
  logic [NUBITS-1:0] m_data;
  logic [OPW-1:0]    m_port;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_port, s_valid, req_in, io_out, out_en, m_ready,
    output s_ready, io_in, m_data, m_port, m_valid
  );

  modport master (
    output s_data, s_port, s_valid, req_in, io_out, out_en, m_ready,
    input  s_ready, io_in, m_data, m_port, m_valid
  );
endinterface

// File: rtl/ssf_io_host.sv
// ssf_io_host: host side of the soft processor I/O ports. Per-port input
// FIFOs feed io_in on req_in strobes; io_out words qualified by out_en are
// captured with their port index into a first-word-fall-through output FIFO.
// Optional SSF_IO_HOST_STATS_EN adds saturating rd_cnt/wr_cnt counters.
module ssf_io_host #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  ssf_io_host_if.slave bus,
  output logic underflow,
  output logic overflow,
  output logic strobe_err
`ifdef SSF_IO_HOST_STATS_EN
  ,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
`endif
);
  localparam int IPW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
  localparam int OPW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;
  localparam int PW  = $clog2(FDEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(FDEPTH);

  // input side storage and state
  logic [NUBITS-1:0] in_mem   [NUIOIN][FDEPTH];
  logic [PW-1:0]     in_wp_q  [NUIOIN];
  logic [PW-1:0]     in_rp_q  [NUIOIN];
  logic [CW-1:0]     in_cnt_q [NUIOIN];
  logic [NUBITS-1:0] hold_q   [NUIOIN];
  logic [IPW-1:0]    last_q;

  // output side storage and state
  logic [OPW+NUBITS-1:0] out_mem [FDEPTH];
  logic [PW-1:0]     out_wp_q, out_rp_q;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;

  logic underflow_q, overflow_q, strobe_err_q;
  logic underflow_d, overflow_d, strobe_err_d;

  logic [IPW-1:0]    rd_p;
  logic [OPW-1:0]    wr_q;
  logic              rd_any, rd_multi, rd_empty, rd_pop;
  logic              wr_any, wr_multi, o_full, o_pop, o_push;
  logic              s_ok, s_push;
  logic [NUIOIN-1:0] push_v, pop_v;

  // lowest set strobe bit wins on both sides
  always_comb begin
    rd_p = '0;
    for (int unsigned i = NUIOIN; i > 0; i--)
      if (bus.req_in[i-1]) rd_p = IPW'(i - 1);
    wr_q = '0;
    for (int unsigned i = NUIOOU; i > 0; i--)
      if (bus.out_en[i-1]) wr_q = OPW'(i - 1);
  end

  assign rd_any   = |bus.req_in;
  assign rd_multi = (bus.req_in & (bus.req_in - NUIOIN'(1))) != '0;
  assign wr_any   = |bus.out_en;
  assign wr_multi = (bus.out_en & (bus.out_en - NUIOOU'(1))) != '0;

  assign rd_empty = (in_cnt_q[rd_p] == '0);
  assign rd_pop   = rd_any && !rd_empty;

  assign s_ok        = int'(bus.s_port) < NUIOIN;
  assign bus.s_ready = s_ok && (in_cnt_q[bus.s_port] != FULL);
  assign s_push      = bus.s_valid && bus.s_ready;

  assign bus.io_in = !rd_any   ? hold_q[last_q] :
                     rd_empty  ? hold_q[rd_p]   : in_mem[rd_p][in_rp_q[rd_p]];

  // per-port push/pop enables
  always_comb begin
    push_v = '0;
    pop_v  = '0;
    if (s_push) push_v[bus.s_port] = 1'b1;
    if (rd_pop) pop_v[rd_p]        = 1'b1;
  end

  assign o_full      = (out_cnt_q == FULL);
  assign bus.m_valid = (out_cnt_q != '0);
  assign o_pop       = bus.m_valid && bus.m_ready;
  // a full FIFO still takes the word when the head leaves on the same edge
  assign o_push      = wr_any && (!o_full || o_pop);
  assign out_cnt_d   = out_cnt_q + CW'(o_push) - CW'(o_pop);

  // head is masked while empty so the port reads zero after reset
  assign bus.m_data = bus.m_valid ? out_mem[out_rp_q][NUBITS-1:0] : '0;
  assign bus.m_port = bus.m_valid ? out_mem[out_rp_q][OPW+NUBITS-1 -: OPW] : '0;

  assign underflow_d  = underflow_q  | (rd_any && rd_empty);
  assign overflow_d   = overflow_q   | (wr_any && !o_push);
  assign strobe_err_d = strobe_err_q | rd_multi | wr_multi;

  // FIFO storage writes (no reset needed, validity tracked by counts)
  always_ff @(posedge clk) begin
    if (s_push) in_mem[bus.s_port][in_wp_q[bus.s_port]] <= bus.s_data;
    if (o_push) out_mem[out_wp_q] <= {wr_q, bus.io_out};
  end

  // input FIFO pointers, counts and per-port hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUIOIN; i++) begin
        in_wp_q[i]  <= '0;
        in_rp_q[i]  <= '0;
        in_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
      end
      last_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUIOIN; i++) begin
        if (push_v[i]) in_wp_q[i] <= in_wp_q[i] + PW'(1);
        if (pop_v[i]) begin
          in_rp_q[i] <= in_rp_q[i] + PW'(1);
          hold_q[i]  <= in_mem[i][in_rp_q[i]];
        end
        in_cnt_q[i] <= in_cnt_q[i] + CW'(push_v[i]) - CW'(pop_v[i]);
      end
      if (rd_any) last_q <= rd_p;
    end
  end

  // output FIFO pointers, count and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wp_q     <= '0;
      out_rp_q     <= '0;
      out_cnt_q    <= '0;
      underflow_q  <= 1'b0;
      overflow_q   <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      if (o_push) out_wp_q <= out_wp_q + PW'(1);
      if (o_pop)  out_rp_q <= out_rp_q + PW'(1);
      out_cnt_q    <= out_cnt_d;
      underflow_q  <= underflow_d;
      overflow_q   <= overflow_d;
      strobe_err_q <= strobe_err_d;
    end
  end

  assign underflow  = underflow_q;
  assign overflow   = overflow_q;
  assign strobe_err = strobe_err_q;

`ifdef SSF_IO_HOST_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  // saturating counts of successful input pops and output pushes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (rd_pop && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (o_push && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif
endmodule

// File: tb/tb_ssf_io_host.sv
// tb_ssf_io_host: scoreboard bench for ssf_io_host. A queue-based reference
// model predicts per-cycle status and output-stream transfers; a monitor
// process compares them against the DUT.
module tb_ssf_io_host;
  localparam int FDEPTH = 8;

  logic clk;
  logic rst;
  logic underflow, overflow, strobe_err;
`ifdef SSF_IO_HOST_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  ssf_io_host_if #(.NUBITS(32), .NUIOIN(2), .NUIOOU(2)) bus ();

  ssf_io_host #(.NUBITS(32), .NUIOIN(2), .NUIOOU(2), .FDEPTH(FDEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .underflow  (underflow),
    .overflow   (overflow),
    .strobe_err (strobe_err)
`ifdef SSF_IO_HOST_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        srdy;
    logic        mv;
    logic        uf;
    logic        of;
    logic        se;
    logic [31:0] io;
  } st_t;

  // reference model state
  logic [31:0] inq [2][$];
  logic [31:0] hold [2];
  int          last;
  logic [32:0] outq [$];
  logic        m_uf, m_of, m_se;
  int          m_rd, m_wr;

  // scoreboard queues
  st_t         st_q [$];
  logic [32:0] exp_m [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    inq[0].delete();
    inq[1].delete();
    hold[0] = '0;
    hold[1] = '0;
    last = 0;
    outq.delete();
    m_uf = 0; m_of = 0; m_se = 0;
    m_rd = 0; m_wr = 0;
  endtask

  task automatic drive_idle();
    bus.s_valid = 0; bus.s_port = 0; bus.s_data = 0;
    bus.req_in = 0; bus.io_out = 0; bus.out_en = 0; bus.m_ready = 0;
  endtask

  // one clock cycle of stimulus plus the model's prediction for it
  task automatic cyc(input logic sv, input logic sp, input logic [31:0] sd,
                     input logic [1:0] rq, input logic [31:0] iod,
                     input logic [1:0] oe, input logic mr);
    st_t  e;
    int   p, q;
    logic srdy, mv;
    @(negedge clk);
    bus.s_valid = sv; bus.s_port = sp; bus.s_data = sd;
    bus.req_in = rq; bus.io_out = iod; bus.out_en = oe; bus.m_ready = mr;
    p    = rq[0] ? 0 : 1;
    q    = oe[0] ? 0 : 1;
    srdy = inq[sp].size() < FDEPTH;
    mv   = outq.size() > 0;
    e.srdy = srdy; e.mv = mv; e.uf = m_uf; e.of = m_of; e.se = m_se;
    if (rq != 0) e.io = (inq[p].size() > 0) ? inq[p][0] : hold[p];
    else         e.io = hold[last];
    st_q.push_back(e);
    if (mv && mr) exp_m.push_back(outq[0]);
    // state after the edge: pops decided on pre-edge contents, then pushes
    if (rq != 0) begin
      last = p;
      if (inq[p].size() > 0) begin
        hold[p] = inq[p].pop_front();
        if (m_rd < 65535) m_rd++;
      end else m_uf = 1;
    end
    if (rq == 2'b11 || oe == 2'b11) m_se = 1;
    if (sv && srdy) inq[sp].push_back(sd);
    if (mv && mr) void'(outq.pop_front());
    if (oe != 0) begin
      if (outq.size() < FDEPTH) begin
        outq.push_back({q[0], iod});
        if (m_wr < 65535) m_wr++;
      end else m_of = 1;
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    drive_idle();
    rst = 0;
    #1;
    if (check) begin
      chk("rst_io_in", bus.io_in, 0);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_m_port", bus.m_port, 0);
      chk("rst_flags", {underflow, overflow, strobe_err}, 0);
      chk("rst_s_ready", bus.s_ready, 1);
    end
    model_clear();
    @(negedge clk);
    rst = 1;
    #1;
    if (check) begin
      chk("rel_s_ready", bus.s_ready, 1);
      chk("rel_m_valid", bus.m_valid, 0);
`ifdef SSF_IO_HOST_STATS_EN
      chk("rel_rd_cnt", rd_cnt, 0);
      chk("rel_wr_cnt", wr_cnt, 0);
`endif
    end
  endtask

  // monitor: per-cycle status and every output-stream transfer
  initial begin
    st_t         e;
    logic [32:0] m;
    forever begin
      @(negedge clk);
      #1;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("s_ready", bus.s_ready, e.srdy);
        chk("m_valid", bus.m_valid, e.mv);
        chk("io_in", bus.io_in, e.io);
        chk("underflow", underflow, e.uf);
        chk("overflow", overflow, e.of);
        chk("strobe_err", strobe_err, e.se);
      end
      if (rst && bus.m_valid && bus.m_ready) begin
        if (exp_m.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL m_unexpected: got port %0d data %0h expected no transfer", bus.m_port, bus.m_data);
        end else begin
          m = exp_m.pop_front();
          chk("m_data", bus.m_data, m[31:0]);
          chk("m_port", bus.m_port, m[32]);
        end
      end
    end
  end

  initial begin
    rst = 0;
    drive_idle();
    model_clear();
    do_reset(1);

    // directed read path, then underflow holding the last word
    cyc(1, 0, 32'h11, 2'b00, 0, 2'b00, 0);
    cyc(1, 0, 32'h22, 2'b00, 0, 2'b00, 0);
    cyc(1, 1, 32'h33, 2'b00, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b10, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 2'b00, 0, 2'b00, 0);

    // output overflow with sink stalled, then drain
    do_reset(1);
    for (int k = 0; k < 9; k++) cyc(0, 0, 0, 2'b00, k, 2'b10, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 2'b00, 0, 2'b00, 1);

    // full output FIFO accepts a push when the head leaves on the same edge
    do_reset(1);
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 2'b00, 32'h100 + k, 2'b01, 0);
    cyc(0, 0, 0, 2'b00, 32'hAA, 2'b01, 1);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 2'b00, 0, 2'b00, 1);

    // multiple req_in bits: lowest port served, strobe_err set
    do_reset(1);
    cyc(1, 0, 32'h5, 2'b00, 0, 2'b00, 0);
    cyc(1, 1, 32'h6, 2'b00, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b11, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b10, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b00, 0, 2'b00, 0);

    // empty FIFO with simultaneous push and pop: no bypass
    do_reset(1);
    cyc(1, 0, 32'h77, 2'b01, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b00, 0, 2'b00, 0);

    // reset mid-stream with words queued on both sides
    do_reset(1);
    cyc(1, 0, 32'hA1, 2'b00, 32'hB1, 2'b01, 0);
    cyc(1, 0, 32'hA2, 2'b00, 32'hB2, 2'b10, 0);
    cyc(1, 0, 32'hA3, 2'b00, 0, 2'b00, 0);
    do_reset(1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r, o;
      logic [1:0] rq, oe;
      r  = $urandom_range(0, 9);
      o  = $urandom_range(0, 9);
      rq = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      oe = (o < 5) ? 2'b00 : (o < 7) ? 2'b01 : (o < 9) ? 2'b10 : 2'b11;
      cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), $urandom,
          rq, $urandom, oe, logic'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 2'b00, 0, 2'b00, 1);
    @(negedge clk);
    #2;
`ifdef SSF_IO_HOST_STATS_EN
    chk("rd_cnt", rd_cnt, m_rd);
    chk("wr_cnt", wr_cnt, m_wr);
`endif
    chk("status_q_empty", st_q.size(), 0);
    chk("m_q_empty", exp_m.size(), 0);
    do_reset(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
